// File: rtl/flit_sched_pkg.sv
// Shared types for the flit slot scheduler: FSM states and the staging slot record.
package flit_sched_pkg;

    // Slot field widths; the scheduler's DATA_WIDTH/ADDRESS_WIDTH default to these.
    localparam int unsigned FS_DATA_W = 128;
    localparam int unsigned FS_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PACK = 2'd1,
        EMIT = 2'd2
    } state_e;

    // One staging slot of the outgoing bundle.
    typedef struct packed {
        logic                 valid;
        logic                 head;
        logic                 tail;
        logic [FS_ADDR_W-1:0] dest;
        logic [FS_ADDR_W-1:0] extra;
        logic [FS_DATA_W-1:0] data;
    } slot_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer wins.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_oh_o,
    output logic [IDX_W-1:0]   gnt_idx_o
);

    int   cand;
    logic found;

    // Scan from the pointer, wrapping, and stop at the first request.
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr_i) + i) % NUM_REQ;
            if (!found && req_i[cand]) begin
                found            = 1'b1;
                gnt_idx_o        = IDX_W'(cand);
                gnt_oh_o[cand]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/flit_slot_scheduler.sv
// Round-robin packet scheduler that packs the locked source's flits into a
// NOC_SPEEDUP-slot bundle and hands it to the flit aggregator.
module flit_slot_scheduler
    import flit_sched_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = FS_DATA_W,
    parameter int ADDRESS_WIDTH = FS_ADDR_W,
    parameter int NOC_SPEEDUP   = 4,
    parameter int FLUSH_TIMEOUT = 8
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic [NUM_REQ-1:0]                     i_req_valid,
    output logic [NUM_REQ-1:0]                     o_req_ready,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     i_req_data,
    input  logic [NUM_REQ-1:0]                     i_req_head,
    input  logic [NUM_REQ-1:0]                     i_req_tail,
    input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0]  i_req_dest,
    input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0]  i_req_extra,
    output logic [DATA_WIDTH-1:0]                  o_data    [0:NOC_SPEEDUP-1],
    output logic [ADDRESS_WIDTH-1:0]               o_dest    [0:NOC_SPEEDUP-1],
    output logic [ADDRESS_WIDTH-1:0]               o_extra   [0:NOC_SPEEDUP-1],
    output logic                                   o_validfl [0:NOC_SPEEDUP-1],
    output logic                                   o_headfl  [0:NOC_SPEEDUP-1],
    output logic                                   o_tailfl  [0:NOC_SPEEDUP-1],
    output logic                                   o_bundle_valid,
    input  logic                                   i_ready_out,
    output logic [$clog2(NUM_REQ)-1:0]             o_grant_id,
    output logic                                   o_busy,
    output logic                                   o_proto_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WR_W  = $clog2(NOC_SPEEDUP);
    localparam int CNT_W = $clog2(FLUSH_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [WR_W-1:0]    wr_idx_q, wr_idx_d;
    logic [CNT_W-1:0]   idle_q, idle_d;
    logic               head_seen_q, head_seen_d;
    logic               err_q, err_d;
    slot_t              slot_q [NOC_SPEEDUP];
    slot_t              slot_d [NOC_SPEEDUP];

    logic [NUM_REQ-1:0] arb_oh;
    logic [IDX_W-1:0]   arb_idx;
    logic               accept;
    logic               tail_held;
    logic               in_head;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i     (i_req_valid & i_req_head),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx)
    );

    assign accept  = (state_q == PACK) && i_req_valid[grant_q];
    assign in_head = i_req_head[grant_q];

    // Does the bundle being emitted carry the packet's tail?
    always_comb begin
        tail_held = 1'b0;
        for (int s = 0; s < NOC_SPEEDUP; s++) tail_held |= slot_q[s].tail;
    end

    // Next-state, packing and handshake logic.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        wr_idx_d    = wr_idx_q;
        idle_d      = idle_q;
        head_seen_d = head_seen_q;
        err_d       = err_q;
        slot_d      = slot_q;
        o_req_ready = '0;
        case (state_q)
            IDLE: begin
                if (|arb_oh) begin
                    grant_d     = arb_idx;
                    head_seen_d = 1'b0;
                    idle_d      = '0;
                    state_d     = PACK;
                end
            end
            PACK: begin
                o_req_ready[grant_q] = 1'b1;
                if (accept) begin
                    slot_d[wr_idx_q].valid = 1'b1;
                    slot_d[wr_idx_q].head  = in_head;
                    slot_d[wr_idx_q].tail  = i_req_tail[grant_q];
                    slot_d[wr_idx_q].data  = i_req_data[grant_q];
                    slot_d[wr_idx_q].dest  = in_head ? i_req_dest[grant_q] : '0;
                    slot_d[wr_idx_q].extra = in_head ? '0 : i_req_extra[grant_q];
                    // A second head in one packet is flagged but packed as a fresh head.
                    if (in_head) begin
                        if (head_seen_q) err_d = 1'b1;
                        head_seen_d = 1'b1;
                    end
                    wr_idx_d = wr_idx_q + WR_W'(1);
                    idle_d   = '0;
                    if (wr_idx_q == WR_W'(NOC_SPEEDUP - 1) || i_req_tail[grant_q])
                        state_d = EMIT;
                end else if (wr_idx_q != '0) begin
                    // Only a non-empty bundle ages toward a flush.
                    if (idle_q == CNT_W'(FLUSH_TIMEOUT - 1)) begin
                        idle_d  = '0;
                        state_d = EMIT;
                    end else begin
                        idle_d = idle_q + CNT_W'(1);
                    end
                end
            end
            EMIT: begin
                if (i_ready_out) begin
                    for (int s = 0; s < NOC_SPEEDUP; s++) slot_d[s] = '0;
                    wr_idx_d = '0;
                    idle_d   = '0;
                    if (tail_held) begin
                        ptr_d   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
                        state_d = IDLE;
                    end else begin
                        state_d = PACK;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and staging registers; reset drops any partially packed packet.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            wr_idx_q    <= '0;
            idle_q      <= '0;
            head_seen_q <= 1'b0;
            err_q       <= 1'b0;
            for (int s = 0; s < NOC_SPEEDUP; s++) slot_q[s] <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            wr_idx_q    <= wr_idx_d;
            idle_q      <= idle_d;
            head_seen_q <= head_seen_d;
            err_q       <= err_d;
            for (int s = 0; s < NOC_SPEEDUP; s++) slot_q[s] <= slot_d[s];
        end
    end

    // Slot registers drive the aggregator arrays directly.
    always_comb begin
        for (int s = 0; s < NOC_SPEEDUP; s++) begin
            o_data[s]    = slot_q[s].data;
            o_dest[s]    = slot_q[s].dest;
            o_extra[s]   = slot_q[s].extra;
            o_validfl[s] = slot_q[s].valid;
            o_headfl[s]  = slot_q[s].head;
            o_tailfl[s]  = slot_q[s].tail;
        end
    end

    assign o_bundle_valid = (state_q == EMIT);
    assign o_grant_id     = grant_q;
    assign o_busy         = (state_q != IDLE);
    assign o_proto_err    = err_q;

endmodule

// File: tb/tb_flit_slot_scheduler.sv
// Scoreboard bench for flit_slot_scheduler: tests push expected bundles,
// a negedge monitor pops and compares every accepted bundle.
module tb_flit_slot_scheduler;

    localparam int NR = 4;
    localparam int DW = 128;
    localparam int AW = 4;
    localparam int NS = 4;
    localparam int FT = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NR-1:0]         req_valid, req_head, req_tail, req_ready;
    logic [NR-1:0][DW-1:0] req_data;
    logic [NR-1:0][AW-1:0] req_dest, req_extra;
    logic [DW-1:0]         o_data    [0:NS-1];
    logic [AW-1:0]         o_dest    [0:NS-1];
    logic [AW-1:0]         o_extra   [0:NS-1];
    logic                  o_validfl [0:NS-1];
    logic                  o_headfl  [0:NS-1];
    logic                  o_tailfl  [0:NS-1];
    logic                  bundle_valid, ready_out, busy, proto_err;
    logic [1:0]            grant_id;
    logic [NS-1:0]         vfl, hfl, tfl;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [NS-1:0]         v, h, t;
        logic [1:0]            g;
        logic [NS-1:0][DW-1:0] d;
        logic [NS-1:0][AW-1:0] dst, ex;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    flit_slot_scheduler #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
        .NOC_SPEEDUP(NS), .FLUSH_TIMEOUT(FT)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_data(req_data), .i_req_head(req_head), .i_req_tail(req_tail),
        .i_req_dest(req_dest), .i_req_extra(req_extra),
        .o_data(o_data), .o_dest(o_dest), .o_extra(o_extra),
        .o_validfl(o_validfl), .o_headfl(o_headfl), .o_tailfl(o_tailfl),
        .o_bundle_valid(bundle_valid), .i_ready_out(ready_out),
        .o_grant_id(grant_id), .o_busy(busy), .o_proto_err(proto_err)
    );

    always_comb begin
        vfl = '0; hfl = '0; tfl = '0;
        for (int s = 0; s < NS; s++) begin
            vfl[s] = o_validfl[s];
            hfl[s] = o_headfl[s];
            tfl[s] = o_tailfl[s];
        end
    end

    function automatic logic [DW-1:0] fdata(int src, int pkt, int i);
        return {32'(pkt), 32'(src), 32'(i), 32'hC0DE_0000 + 32'(i)};
    endfunction
    function automatic logic [AW-1:0] fdest(int src, int pkt);
        return AW'(src + pkt + 1);
    endfunction
    function automatic logic [AW-1:0] fextra(int pkt, int i);
        return AW'(pkt * 3 + i + 1);
    endfunction

    // Scoreboard monitor: every bundle the aggregator accepts is compared to the queue head.
    always @(negedge clk) begin
        exp_t e;
        logic bad;
        if (rst_n && bundle_valid && ready_out) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL bundle_unexpected: got valid=%b grant=%0d, required no bundle", vfl, grant_id);
            end else begin
                e   = sb.pop_front();
                bad = 1'b0;
                for (int s = 0; s < NS; s++)
                    if (o_data[s] !== e.d[s] || o_dest[s] !== e.dst[s] || o_extra[s] !== e.ex[s]) bad = 1'b1;
                if (vfl !== e.v || hfl !== e.h || tfl !== e.t || grant_id !== e.g || bad) begin
                    errors++;
                    $display("FAIL bundle: got v=%b h=%b t=%b g=%0d d0=%h dst0=%h ex1=%h, required v=%b h=%b t=%b g=%0d d0=%h dst0=%h ex1=%h",
                             vfl, hfl, tfl, grant_id, o_data[0], o_dest[0], o_extra[1],
                             e.v, e.h, e.t, e.g, e.d[0], e.dst[0], e.ex[1]);
                end
            end
        end
    end

    // Expected bundle holding flits first..last of a packet of n flits.
    task automatic push_bundle(int src, int pkt, int n, logic [15:0] hm, int first, int last);
        exp_t e;
        e   = '0;
        e.g = 2'(src);
        for (int i = first; i <= last; i++) begin
            int s = i - first;
            e.v[s]   = 1'b1;
            e.h[s]   = hm[i];
            e.t[s]   = (i == n - 1);
            e.d[s]   = fdata(src, pkt, i);
            e.dst[s] = hm[i] ? fdest(src, pkt) : '0;
            e.ex[s]  = hm[i] ? '0 : fextra(pkt, i);
        end
        sb.push_back(e);
    endtask

    task automatic expect_pkt(int src, int pkt, int n, logic [15:0] hm);
        for (int f = 0; f < n; f += NS)
            push_bundle(src, pkt, n, hm, f, (f + NS - 1 < n - 1) ? f + NS - 1 : n - 1);
    endtask

    task automatic send_flit(int src, int pkt, int i, bit h, bit t);
        int c = 0;
        @(negedge clk);
        req_valid[src] = 1'b1;
        req_head[src]  = h;
        req_tail[src]  = t;
        req_data[src]  = fdata(src, pkt, i);
        req_dest[src]  = fdest(src, pkt);
        req_extra[src] = fextra(pkt, i);
        checks++;
        while (req_ready[src] !== 1'b1) begin
            @(negedge clk);
            c++;
            if (c > 300) begin
                errors++;
                $display("FAIL handshake_timeout: src=%0d flit=%0d ready=%b, required ready=1", src, i, req_ready);
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid[src] = 1'b0;
        req_head[src]  = 1'b0;
        req_tail[src]  = 1'b0;
    endtask

    task automatic send_pkt(int src, int pkt, int n, logic [15:0] hm);
        for (int i = 0; i < n; i++) send_flit(src, pkt, i, hm[i], i == n - 1);
    endtask

    task automatic drain(output bit ok);
        int c = 0;
        ok = 1'b1;
        while (sb.size() != 0 || busy) begin
            @(negedge clk);
            c++;
            if (c > 300) begin ok = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        checks++;
        if (bundle_valid !== 1'b0 || req_ready !== '0 || busy !== 1'b0 || grant_id !== '0 ||
            proto_err !== 1'b0 || vfl !== '0 || hfl !== '0 || tfl !== '0 || o_data[0] !== '0) begin
            errors++;
            $display("FAIL reset_state: bv=%b rdy=%b busy=%b g=%0d err=%b v=%b, required all 0",
                     bundle_valid, req_ready, busy, grant_id, proto_err, vfl);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bundle_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b bv=%b, required 0 0", busy, bundle_valid);
        end
    endtask

    task automatic test_rr();
        bit ok;
        expect_pkt(0, 1, 2, 16'h1);
        expect_pkt(2, 2, 2, 16'h1);
        fork
            send_pkt(0, 1, 2, 16'h1);
            send_pkt(2, 2, 2, 16'h1);
        join
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rr_drain: pending=%0d busy=%b, required 0 0", sb.size(), busy);
        end
    endtask

    task automatic test_single_bundle();
        bit ok;
        expect_pkt(1, 3, 4, 16'h1);
        send_pkt(1, 3, 4, 16'h1);
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_drain: pending=%0d busy=%b, required 0 0", sb.size(), busy);
        end
    endtask

    task automatic test_multi_bundle();
        bit ok;
        expect_pkt(0, 4, 6, 16'h1);
        send_pkt(0, 4, 6, 16'h1);
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL multi_drain: pending=%0d busy=%b, required 0 0", sb.size(), busy);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        push_bundle(3, 6, 2, 16'h1, 0, 0);
        push_bundle(3, 6, 2, 16'h1, 1, 1);
        send_flit(3, 6, 0, 1'b1, 1'b0);
        for (int j = 0; j < FT; j++) begin
            @(negedge clk);
            checks++;
            if (bundle_valid !== 1'b0) begin
                errors++;
                $display("FAIL early_flush: idle cycle %0d bv=%b, required 0", j, bundle_valid);
            end
        end
        @(negedge clk);
        checks++;
        if (bundle_valid !== 1'b1 || vfl !== 4'b0001) begin
            errors++;
            $display("FAIL timeout_flush: bv=%b v=%b, required 1 0001", bundle_valid, vfl);
        end
        send_flit(3, 6, 1, 1'b0, 1'b1);
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL timeout_drain: pending=%0d busy=%b, required 0 0", sb.size(), busy);
        end
    endtask

    task automatic test_stall();
        ready_out = 1'b0;
        expect_pkt(2, 5, 1, 16'h1);
        send_pkt(2, 5, 1, 16'h1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (bundle_valid !== 1'b1 || req_ready !== '0 || vfl !== 4'b0001 || tfl !== 4'b0001 ||
                o_data[0] !== fdata(2, 5, 0) || o_dest[0] !== fdest(2, 5)) begin
                errors++;
                $display("FAIL stall_hold: cyc=%0d bv=%b rdy=%b v=%b d0=%h, required 1 0000 0001 %h",
                         k, bundle_valid, req_ready, vfl, o_data[0], fdata(2, 5, 0));
            end
        end
        @(posedge clk);
        #1;
        ready_out = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (bundle_valid !== 1'b0 || sb.size() != 0 || vfl !== '0) begin
            errors++;
            $display("FAIL stall_release: bv=%b pending=%0d v=%b, required 0 0 0000", bundle_valid, sb.size(), vfl);
        end
    endtask

    task automatic test_proto_err();
        bit ok;
        expect_pkt(1, 7, 3, 16'h3);
        send_pkt(1, 7, 3, 16'h3);
        drain(ok);
        checks++;
        if (!ok || proto_err !== 1'b1) begin
            errors++;
            $display("FAIL proto_err_set: err=%b drained=%b, required 1 1", proto_err, ok);
        end
        expect_pkt(3, 8, 1, 16'h1);
        send_pkt(3, 8, 1, 16'h1);
        drain(ok);
        checks++;
        if (!ok || proto_err !== 1'b1) begin
            errors++;
            $display("FAIL proto_err_sticky: err=%b drained=%b, required 1 1", proto_err, ok);
        end
    endtask

    task automatic test_reset_mid();
        send_flit(2, 9, 0, 1'b1, 1'b0);
        send_flit(2, 9, 1, 1'b0, 1'b0);
        #2;
        checks++;
        if (busy !== 1'b1 || vfl !== 4'b0011 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL mid_pack: busy=%b v=%b g=%0d, required 1 0011 2", busy, vfl, grant_id);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bundle_valid !== 1'b0 || req_ready !== '0 || busy !== 1'b0 || grant_id !== '0 ||
            proto_err !== 1'b0 || vfl !== '0 || hfl !== '0 || o_data[0] !== '0 || o_data[1] !== '0) begin
            errors++;
            $display("FAIL async_reset: bv=%b rdy=%b busy=%b g=%0d err=%b v=%b d0=%h, required all 0",
                     bundle_valid, req_ready, busy, grant_id, proto_err, vfl, o_data[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b pending=%0d, required 0 0", busy, sb.size());
        end
    endtask

    initial begin
        req_valid = '0; req_head = '0; req_tail = '0;
        req_data = '0; req_dest = '0; req_extra = '0;
        ready_out = 1'b1;
        test_reset();
        test_rr();
        test_single_bundle();
        test_multi_bundle();
        test_timeout();
        test_stall();
        test_proto_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
